// File: rtl/obi_slave_adapter.sv
// obi_slave_adapter: OBI responder for a fixed-latency peripheral.
// Credit-limited grants, tag pipe and an in-order response FIFO.
module obi_slave_adapter #(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        p_req_o,
  output logic [31:0] p_addr_o,
  output logic        p_we_o,
  output logic [3:0]  p_be_o,
  output logic [31:0] p_wdata_o,
  input  logic [31:0] p_rdata_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CMAX  = CW'(DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] fcnt;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [31:0]   fdata [DEPTH];
  logic          ferr  [DEPTH];

  logic [LATENCY-1:0] tv;
  logic [LATENCY-1:0] te;
  logic [LATENCY-1:0] tw;

  logic        hs;
  logic        bad;
  logic        push;
  logic        pop;
  logic        cerr;
  logic [31:0] cap;

  assign gnt_o = req_i & (cnt < CMAX) & ~rst_i;
  assign hs    = req_i & gnt_o;
  assign bad   = (be_i == 4'b0000);

  assign p_req_o   = hs & ~bad;
  assign p_we_o    = we_i & p_req_o;
  assign p_addr_o  = addr_i;
  assign p_be_o    = be_i;
  assign p_wdata_o = wdata_i;

  assign push = tv[LATENCY-1];
  assign cerr = te[LATENCY-1];
  assign cap  = (cerr | tw[LATENCY-1]) ? '0 : p_rdata_i;

  assign rvalid_o = (fcnt != '0);
  assign pop      = rvalid_o & rready_i;
  // Gate the head so idle/reset output is zero without clearing storage.
  assign rdata_o  = rvalid_o ? fdata[rptr] : '0;
  assign err_o    = rvalid_o & ferr[rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tv <= '0;
      te <= '0;
      tw <= '0;
    end else begin
      tv[0] <= hs;
      te[0] <= bad;
      tw[0] <= we_i;
      for (int i = 1; i < LATENCY; i++) begin
        tv[i] <= tv[i-1];
        te[i] <= te[i-1];
        tw[i] <= tw[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fdata[wptr] <= cap;
      ferr[wptr]  <= cerr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == PLAST) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == PLAST) ? '0 : rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
      unique case ({hs, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
